// File: rtl/ascon_permutation_engine.sv
// Iterative Ascon permutation core (p12/p8/p6). It accepts a 320-bit state on start,
// runs ROUNDS_PER_CYCLE rounds per busy cycle, and returns the result with a one-cycle done pulse.
module ascon_permutation_engine #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  rounds_sel,
   input  logic [63:0] x0_i,
   input  logic [63:0] x1_i,
   input  logic [63:0] x2_i,
   input  logic [63:0] x3_i,
   input  logic [63:0] x4_i,
   output logic        busy,
   output logic        done,
   output logic [63:0] x0_o,
   output logic [63:0] x1_o,
   output logic [63:0] x2_o,
   output logic [63:0] x3_o,
   output logic [63:0] x4_o
);

   localparam logic       ST_IDLE = 1'b0;
   localparam logic       ST_RUN  = 1'b1;
   localparam logic [3:0] RPC     = 4'(ROUNDS_PER_CYCLE);

   if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2) begin : g_bad_rpc
      $error("ascon_permutation_engine: ROUNDS_PER_CYCLE must be 1 or 2");
   end

   function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // One full Ascon round on the state packed as {x0, x1, x2, x3, x4}.
   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
      logic [63:0] a0, a1, a2, a3, a4;
      logic [63:0] t0, t1, t2, t3, t4;
      a0 = s[319:256];
      a1 = s[255:192];
      a2 = s[191:128];
      a3 = s[127:64];
      a4 = s[63:0];
      a2 = a2 ^ {56'h0, 4'hf - r, r};
      a0 = a0 ^ a4;
      a4 = a4 ^ a3;
      a2 = a2 ^ a1;
      t0 = ~a0 & a1;
      t1 = ~a1 & a2;
      t2 = ~a2 & a3;
      t3 = ~a3 & a4;
      t4 = ~a4 & a0;
      a0 = a0 ^ t1;
      a1 = a1 ^ t2;
      a2 = a2 ^ t3;
      a3 = a3 ^ t4;
      a4 = a4 ^ t0;
      a1 = a1 ^ a0;
      a0 = a0 ^ a4;
      a3 = a3 ^ a2;
      a2 = ~a2;
      a0 = a0 ^ ror64(a0, 19) ^ ror64(a0, 28);
      a1 = a1 ^ ror64(a1, 61) ^ ror64(a1, 39);
      a2 = a2 ^ ror64(a2, 1)  ^ ror64(a2, 6);
      a3 = a3 ^ ror64(a3, 10) ^ ror64(a3, 17);
      a4 = a4 ^ ror64(a4, 7)  ^ ror64(a4, 41);
      return {a0, a1, a2, a3, a4};
   endfunction

   logic           state_q, state_d;
   logic [3:0]     r_q, r_d;
   logic [319:0]   s_q, s_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic [319:0]   out_q, out_d;

   logic [319:0]   rnd1_s, rnd2_s, perm_s;
   logic [3:0]     r0_s;
   logic           last_s;

   // Round datapath shared by every phase; the second round is only used when two rounds run per cycle.
   always_comb begin
      rnd1_s = ascon_round(s_q, r_q);
      rnd2_s = ascon_round(rnd1_s, r_q + 4'd1);
      perm_s = (ROUNDS_PER_CYCLE == 2) ? rnd2_s : rnd1_s;
      last_s = ((r_q + RPC) == 4'd12);
   end

   // Starting round index 12-N; the reserved selector runs the full p12.
   always_comb begin
      r0_s = 4'd0;
      case (rounds_sel)
         2'b00:   r0_s = 4'd0;
         2'b01:   r0_s = 4'd4;
         2'b10:   r0_s = 4'd6;
         default: r0_s = 4'd0;
      endcase
   end

   // Next-state logic for the IDLE/RUN controller, working state and result registers.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      s_d     = s_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      out_d   = out_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               s_d     = {x0_i, x1_i, x2_i, x3_i, x4_i};
               r_d     = r0_s;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_s) begin
               state_d = ST_IDLE;
               s_d     = perm_s;
               r_d     = 4'd0;
               out_d   = perm_s;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               s_d     = perm_s;
               r_d     = r_q + RPC;
            end
         end
         default: begin
            state_d = ST_IDLE;
            r_d     = 4'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset; a reset mid-run discards the permutation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         r_q     <= 4'd0;
         s_q     <= 320'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= 320'd0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         s_q     <= s_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         out_q   <= out_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign x0_o = out_q[319:256];
   assign x1_o = out_q[255:192];
   assign x2_o = out_q[191:128];
   assign x3_o = out_q[127:64];
   assign x4_o = out_q[63:0];

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Scoreboard bench for ascon_permutation_engine: one instance per ROUNDS_PER_CYCLE value,
// checked against a table-driven column-wise reference permutation.
module tb_ascon_permutation_engine;

   typedef logic [4:0][63:0] st_t;   // index i holds word x_i
   typedef struct {
      st_t exp;
      int  acc;
      int  due;
   } item_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_s   [2];
   logic       start_s [2];
   logic [1:0] sel_s   [2];
   st_t        xi_s    [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   st_t        xo_s    [2];

   int    cyc = 0;
   bit    mon_en = 1'b0;
   int    n_vec = 0;
   int    n_fail = 0;
   int    n_acc [2];
   int    n_done [2];
   int    free_edge [2];
   st_t   last_out [2];
   item_t q0 [$];
   item_t q1 [$];

   int SBOX [32] = '{4, 11, 31, 20, 26, 21, 9, 2, 27, 5, 8, 18, 29, 3, 6, 28,
                     30, 19, 7, 14, 0, 13, 17, 24, 16, 12, 1, 25, 22, 10, 15, 23};
   int ROT_A [5] = '{19, 61, 1, 10, 7};
   int ROT_B [5] = '{28, 39, 6, 17, 41};

   ascon_permutation_engine #(.ROUNDS_PER_CYCLE(1)) u_dut1 (
      .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .rounds_sel(sel_s[0]),
      .x0_i(xi_s[0][0]), .x1_i(xi_s[0][1]), .x2_i(xi_s[0][2]), .x3_i(xi_s[0][3]), .x4_i(xi_s[0][4]),
      .busy(busy_s[0]), .done(done_s[0]),
      .x0_o(xo_s[0][0]), .x1_o(xo_s[0][1]), .x2_o(xo_s[0][2]), .x3_o(xo_s[0][3]), .x4_o(xo_s[0][4])
   );

   ascon_permutation_engine #(.ROUNDS_PER_CYCLE(2)) u_dut2 (
      .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .rounds_sel(sel_s[1]),
      .x0_i(xi_s[1][0]), .x1_i(xi_s[1][1]), .x2_i(xi_s[1][2]), .x3_i(xi_s[1][3]), .x4_i(xi_s[1][4]),
      .busy(busy_s[1]), .done(done_s[1]),
      .x0_o(xo_s[1][0]), .x1_o(xo_s[1][1]), .x2_o(xo_s[1][2]), .x3_o(xo_s[1][3]), .x4_o(xo_s[1][4])
   );

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   function automatic int nrounds(input logic [1:0] sel);
      if (sel == 2'b01) return 8;
      else if (sel == 2'b10) return 6;
      else return 12;
   endfunction

   // Reference: per-column S-box lookup (x0 is the MSB of each 5-bit column).
   function automatic st_t ref_perm(input st_t s, input int n);
      logic [63:0] x [5];
      logic [63:0] y [5];
      int idx, o;
      st_t res;
      for (int i = 0; i < 5; i++) x[i] = s[i];
      for (int r = 12 - n; r < 12; r++) begin
         x[2] = x[2] ^ 64'((15 - r) * 16 + r);
         for (int j = 0; j < 64; j++) begin
            idx = 0;
            for (int i = 0; i < 5; i++) idx = idx * 2 + int'(x[i][j]);
            o = SBOX[idx];
            for (int i = 0; i < 5; i++) y[i][j] = o[4 - i];
         end
         for (int i = 0; i < 5; i++) x[i] = y[i] ^ ror(y[i], ROT_A[i]) ^ ror(y[i], ROT_B[i]);
      end
      for (int i = 0; i < 5; i++) res[i] = x[i];
      return res;
   endfunction

   function automatic st_t rand_state();
      st_t s;
      for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
      return s;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_unit(input int u);
      item_t f;
      bit    have;
      logic  exp_busy;
      have = 1'b0;
      if (u == 0) begin
         if (q0.size() > 0) begin have = 1'b1; f = q0[0]; end
      end else begin
         if (q1.size() > 0) begin have = 1'b1; f = q1[0]; end
      end
      exp_busy = have && (cyc >= f.acc) && (cyc < f.due);
      n_vec++;
      if (busy_s[u] !== exp_busy) begin
         n_fail++;
         $display("FAIL u%0d busy @%0d: got %b exp %b", u, cyc, busy_s[u], exp_busy);
      end
      if (done_s[u] === 1'b1) begin
         n_done[u]++;
         n_vec++;
         if (!have) begin
            n_fail++;
            $display("FAIL u%0d unexpected done @%0d: got 1 exp 0", u, cyc);
         end else begin
            if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            if (cyc != f.due) begin
               n_fail++;
               $display("FAIL u%0d latency: done at %0d exp %0d", u, cyc, f.due);
            end
            last_out[u] = f.exp;
         end
      end else if (have && cyc >= f.due) begin
         n_vec++;
         n_fail++;
         $display("FAIL u%0d missing done @%0d: got 0 exp 1", u, cyc);
         if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      n_vec++;
      if (xo_s[u] !== last_out[u]) begin
         n_fail++;
         $display("FAIL u%0d data @%0d: got %h exp %h", u, cyc, xo_s[u], last_out[u]);
      end
   endtask

   // Monitor: samples both instances 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         for (int u = 0; u < 2; u++) check_unit(u);
      end
   end

   task automatic issue(input int u, input logic [1:0] sel, input st_t st);
      item_t it;
      int    e;
      @(negedge clk);
      start_s[u] = 1'b1;
      sel_s[u]   = sel;
      xi_s[u]    = st;
      e = cyc + 1;
      if (e > free_edge[u]) begin
         it.exp = ref_perm(st, nrounds(sel));
         it.acc = e;
         it.due = e + nrounds(sel) / (u + 1);
         free_edge[u] = it.due;
         n_acc[u]++;
         if (u == 0) q0.push_back(it); else q1.push_back(it);
      end
   endtask

   task automatic release_start(input int u);
      @(negedge clk);
      start_s[u] = 1'b0;
      sel_s[u]   = 2'($urandom_range(0, 3));
      xi_s[u]    = rand_state();
   endtask

   // Returns at the negedge just before the done cycle so the next issue lands in it.
   task automatic wait_idle(input int u);
      while (cyc + 1 < free_edge[u]) @(negedge clk);
   endtask

   task automatic abort_run(input int u);
      st_t z;
      z = '0;
      issue(u, 2'b00, rand_state());
      release_start(u);
      repeat (4) @(negedge clk);
      rst_s[u] = 1'b1;
      if (u == 0) q0.delete(); else q1.delete();
      n_acc[u]--;
      last_out[u]  = z;
      free_edge[u] = cyc + 1;
      @(negedge clk);
      rst_s[u] = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   task automatic run_unit(input int u);
      st_t iv, zero;
      iv[0] = 64'h80400c0600000000;
      iv[1] = 64'h0001020304050607;
      iv[2] = 64'h08090a0b0c0d0e0f;
      iv[3] = 64'h0001020304050607;
      iv[4] = 64'h08090a0b0c0d0e0f;
      zero  = '0;
      issue(u, 2'b00, iv);   release_start(u); wait_idle(u);
      issue(u, 2'b01, zero); release_start(u); wait_idle(u);
      issue(u, 2'b10, zero); release_start(u); wait_idle(u);
      issue(u, 2'b11, iv);   release_start(u); wait_idle(u);
      // Start while busy must be ignored.
      issue(u, 2'b00, rand_state()); release_start(u);
      repeat (1) @(negedge clk);
      issue(u, 2'b10, rand_state()); release_start(u); wait_idle(u);
      // Back-to-back: second request issued in the done cycle of the first.
      issue(u, 2'b01, rand_state()); release_start(u); wait_idle(u);
      issue(u, 2'b10, rand_state()); release_start(u); wait_idle(u);
      repeat (3) @(negedge clk);
      abort_run(u);
      for (int k = 0; k < 1000; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(u, 2'($urandom_range(0, 3)), rand_state());
         release_start(u);
         if ($urandom_range(0, 3) == 0) begin
            issue(u, 2'($urandom_range(0, 3)), rand_state());
            release_start(u);
         end
         wait_idle(u);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      for (int u = 0; u < 2; u++) begin
         rst_s[u] = 1'b1; start_s[u] = 1'b0; sel_s[u] = 2'b00; xi_s[u] = '0;
         n_acc[u] = 0; n_done[u] = 0; free_edge[u] = 0; last_out[u] = '0;
      end
      repeat (3) @(negedge clk);
      rst_s[0] = 1'b0;
      rst_s[1] = 1'b0;
      mon_en   = 1'b1;
      repeat (2) @(negedge clk);
      for (int u = 0; u < 2; u++) run_unit(u);
      repeat (4) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         n_vec++;
         if (n_done[u] != n_acc[u]) begin
            n_fail++;
            $display("FAIL u%0d done count: got %0d exp %0d", u, n_done[u], n_acc[u]);
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ascon_permutation_engine.md
Name: ascon_permutation_engine

Overview:
- Iterative multi-cycle Ascon permutation core (p12 / p8 / p6). It is the responder side of the permutation interface used by the init, associated-data, encrypt/decrypt and finalization blocks.
- Accepts a 320-bit state x0..x4 on a start strobe and applies the selected round count, ROUNDS_PER_CYCLE rounds per clock.
- Returns the permuted state with a one-cycle done pulse.
- Lets the top level share one round datapath among all phases instead of instantiating a combinational p8/p12 per phase.

Parameters:
- ROUNDS_PER_CYCLE, 1: Ascon rounds applied per busy cycle. Legal values are 1 and 2; any other value is a elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request strobe; accepted only when busy=0
- rounds_sel  input  2  00: p12, 01: p8, 10: p6, 11: reserved, treated as p12
- x0_i  input  64  state word 0, sampled on accepted start
- x1_i  input  64  state word 1
- x2_i  input  64  state word 2
- x3_i  input  64  state word 3
- x4_i  input  64  state word 4
- busy  output  1  high while a permutation is in progress
- done  output  1  one-cycle pulse; x*_o valid from this cycle
- x0_o  output  64  permuted word 0, registered, held until next done
- x1_o  output  64  permuted word 1
- x2_o  output  64  permuted word 2
- x3_o  output  64  permuted word 3
- x4_o  output  64  permuted word 4

Behaviour:
- Reset (rst=1 at a clk edge): state goes to IDLE; busy=0, done=0, x0_o..x4_o=0, internal state and round index cleared. Reset mid-permutation aborts the permutation and never produces done.
- FSM has two states, IDLE and RUN.
- IDLE with start=1:
  - Latch x0_i..x4_i into the internal state.
  - Set the round index r0 = 12-N, where N = 12, 8 or 6 per rounds_sel.
  - Set busy=1 and move to RUN.
  - rounds_sel is sampled only at this point.
- RUN, each cycle: apply ROUNDS_PER_CYCLE rounds to the internal state and advance r by ROUNDS_PER_CYCLE.
- Last RUN cycle (r + ROUNDS_PER_CYCLE = 12):
  - Write the combinational round result straight into x0_o..x4_o.
  - At the same edge: done=1 and busy=0, then return to IDLE.
- done is high for exactly one cycle.
- start is ignored while busy=1; the inputs are not re-sampled and no queuing occurs.
- start is accepted in the cycle done=1 (busy is already 0), so back-to-back operation is possible.
- Latency: start accepted at edge k; done=1 after edge k+N/ROUNDS_PER_CYCLE. Throughput is one permutation per N/ROUNDS_PER_CYCLE+1 cycles.
- Each round, applied in this order:
  - Constant addition: x2 ^= c_r, with c_r = {56'b0, (4'hf - r[3:0]), r[3:0]} (0xf0, 0xe1, ..., 0x4b).
  - Substitution layer: the 5-bit Ascon S-box, bitsliced across the 64 columns, with x0 as the MSB. Sequence:
    - x0^=x4, x4^=x3, x2^=x1
    - t_i = ~x_i & x_(i+1 mod 5)
    - x_i ^= t_(i+1 mod 5)
    - x1^=x0, x0^=x4, x3^=x2, x2=~x2
  - Linear layer (ror = rotate right of a 64-bit word):
    - x0 ^= ror19(x0) ^ ror28(x0)
    - x1 ^= ror61(x1) ^ ror39(x1)
    - x2 ^= ror1(x2) ^ ror6(x2)
    - x3 ^= ror10(x3) ^ ror17(x3)
    - x4 ^= ror7(x4) ^ ror41(x4)
- With ROUNDS_PER_CYCLE=2, the two rounds in a cycle use constants c_r and c_(r+1). The valid round counts 12, 8 and 6 are all even.
- x*_o change only at the done edge or on reset; they are stable throughout busy.

Test Plan:
- Reset, then idle: busy=0, done=0, all x*_o=0. Assert rst for 1 cycle in the middle of a p12 run (the 5th RUN cycle) -> no done; busy=0 on the next cycle; outputs 0.
- p12 with ROUNDS_PER_CYCLE=1:
  - Input x0..x4 = 0x80400c0600000000, key words, nonce words (the Ascon-128 IV || K || N init state).
  - Expect done exactly 12 cycles after start and x*_o equal to the golden ascon-c p12 output.
  - Also expect busy=1 in cycles 1..11 and busy=0 in the done cycle.
- p8 and p6 (rounds_sel=01, 10) on the all-zero state:
  - done after 8 and 6 cycles respectively (4 and 3 when ROUNDS_PER_CYCLE=2).
  - Outputs match the golden model; this checks that the first constant is 0xb4 (p8) and 0x96 (p6).
- rounds_sel=11 -> identical result and latency to p12. start pulsed while busy=1 with different x*_i -> ignored; the output matches the first request only.
- Back-to-back: assert start in the done cycle with a new state -> the second request is accepted, and its done comes N/ROUNDS_PER_CYCLE cycles later. x*_o hold the first result until then.
- Random regression: 1000 random states and rounds_sel values, for both ROUNDS_PER_CYCLE=1 and 2 -> bit-exact match to the golden model. done count equals the accepted start count.
